sliding_board_engine: RTL
=========================

Name: sliding_board_engine

Overview:
Parametrised sliding-puzzle board engine for a DIM x DIM board.
- Holds the packed board state and tracks the empty cell.
- Executes move commands through a valid/ready handshake and rejects illegal moves with a flag.
- Counts legal moves and registers a win indication.
- Sits between the keyboard/command decoder and the VGA board renderer; it replaces the fixed 4x4 FSM/datapath pair.

Parameters:
- DIM, 4, board edge length in cells; legal range 2..8.
- TILE_W, 4, bits per cell; must be >= clog2(DIM*DIM).
- CNT_W, 16, move counter width.
- Localparams: CELLS = DIM*DIM, IDX_W = clog2(CELLS), BW = CELLS*TILE_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle pulse; load init_board/init_empty.
- init_board  in  BW  initial board, packed as below.
- init_empty  in  IDX_W  index of the empty cell in init_board.
- cmd_valid  in  1  move command valid.
- cmd  in  3  3'b001 up, 3'b010 down, 3'b011 left, 3'b100 right; other codes are no-op.
- cmd_ready  out  1  high only in IDLE.
- board  out  BW  current board.
- empty_idx  out  IDX_W  current empty cell index.
- move_count  out  CNT_W  legal moves since last load.
- move_done  out  1  one-cycle pulse after a legal move completes.
- illegal  out  1  one-cycle pulse on a rejected move.
- win  out  1  board equals solved pattern (registered).

Behaviour:
- Packing: cell i occupies board[i*TILE_W +: TILE_W]. Cell 0 is top-left, row-major; row = i/DIM, col = i%DIM. Value 0 marks the empty cell.
- Solved pattern: cell i holds i+1 for i < CELLS-1; the last cell holds 0.
- Reset (async): state=IDLE, board=0, empty_idx=0, move_count=0, move_done=0, illegal=0, win=0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid with a valid code, latch cmd and go to EXEC. Invalid codes are consumed with no effect and no pulse.
  - EXEC: evaluate legality of the latched command against empty_idx.
    - Legal: swap the neighbour tile into empty_idx, write 0 at the neighbour, set empty_idx=neighbour, increment move_count, go to WCHK.
    - Illegal: pulse illegal, go to IDLE.
  - WCHK: win <= (board == solved). Pulse move_done for moves only, not for loads. Go to IDLE.
- Direction semantics (the tile moves into the gap):
  - up: neighbour = empty+DIM; legal iff row < DIM-1.
  - down: neighbour = empty-DIM; legal iff row > 0.
  - left: neighbour = empty+1; legal iff col < DIM-1.
  - right: neighbour = empty-1; legal iff col > 0.
  - No wrap-around between rows.
- Latency:
  - Command accepted at edge t: board and empty_idx update at t+1, win and move_done at t+2, cmd_ready high again at t+2.
  - Illegal: illegal asserted at t+1, cmd_ready high at t+1.
- move_count saturates at 2^CNT_W-1. The move is still performed; only the counter stops.
- load:
  - Highest priority in any state; aborts an in-flight command without a pulse.
  - Next edge: board=init_board, empty_idx=init_empty, move_count=0, win=0, state=WCHK, no move_done.
  - win is therefore valid 2 cycles after load.
- load and cmd_valid in the same IDLE cycle: the load wins and the command is not accepted (cmd_ready drops).
- init_board is not validated. If init_empty does not point at a 0 cell, moves still swap by index.
- Outputs are register-driven except cmd_ready, which is decoded from state.

Test Plan (DIM=4, TILE_W=4):
- Load 64'h0FED_CBA9_8765_4321 with init_empty=15 -> two cycles later win=1, move_count=0, cmd_ready=1, no move_done.
- From solved, cmd=down -> board=64'hCFED_0BA9_8765_4321, empty_idx=11, move_count=1, move_done pulse at t+2, win=0. Then cmd=up -> solved board, empty_idx=15, move_count=2, win=1.
- From empty_idx=15, cmd=up and then cmd=left -> illegal pulse each at t+1, board/empty_idx/move_count unchanged, no move_done. From empty_idx=4, cmd=right -> illegal (no row wrap).
- Hold cmd_valid high with cmd=down for 6 cycles -> exactly 2 accepted moves (one per 3-cycle IDLE/EXEC/WCHK round): empty_idx 15->11->7, move_count=2.
- Assert load during EXEC -> loaded board appears next edge, move_count=0, no move_done/illegal. Assert resetn mid-WCHK -> all outputs zero immediately, without waiting for a clock edge.
- CNT_W=2: perform 5 legal alternating down/up moves -> move_count stops at 3, board keeps updating correctly.

Source files
------------

// File: rtl/sliding_board_engine.sv
// Sliding-puzzle board engine: holds a DIM x DIM packed board, executes
// tile moves through a valid/ready handshake, counts moves and flags a win.
module sliding_board_engine #(
  parameter int DIM    = 4,
  parameter int TILE_W = 4,
  parameter int CNT_W  = 16,
  localparam int CELLS = DIM*DIM,
  localparam int IDX_W = $clog2(CELLS),
  localparam int BW    = CELLS*TILE_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [BW-1:0]    init_board,
  input  logic [IDX_W-1:0] init_empty,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  output logic             cmd_ready,
  output logic [BW-1:0]    board,
  output logic [IDX_W-1:0] empty_idx,
  output logic [CNT_W-1:0] move_count,
  output logic             move_done,
  output logic             illegal,
  output logic             win
);

  typedef enum logic [1:0] {IDLE, EXEC, WCHK} state_t;

  localparam logic [IDX_W-1:0] DIM_I = IDX_W'(DIM);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

  function automatic logic [BW-1:0] solved_f();
    logic [BW-1:0] s;
    s = '0;
    for (int i = 0; i < CELLS - 1; i++) s[i*TILE_W +: TILE_W] = TILE_W'(i + 1);
    return s;
  endfunction

  localparam logic [BW-1:0] SOLVED = solved_f();

  state_t             r_state, w_next;
  logic [2:0]         r_cmd;
  logic [BW-1:0]      r_board;
  logic [IDX_W-1:0]   r_empty;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_move_done, r_illegal, r_win, r_from_load;

  logic [IDX_W-1:0]   w_row, w_col, w_nbr;
  logic               w_legal, w_code_ok, w_accept;
  logic [TILE_W-1:0]  w_tile;

  assign w_row     = r_empty / DIM_I;
  assign w_col     = r_empty % DIM_I;
  assign w_code_ok = (cmd == 3'b001) || (cmd == 3'b010) || (cmd == 3'b011) || (cmd == 3'b100);
  assign w_accept  = (r_state == IDLE) && cmd_valid && !load;
  assign w_tile    = r_board[w_nbr*TILE_W +: TILE_W];

  // The neighbour index may wrap when the move is illegal; it is unused then.
  always_comb begin
    w_legal = 1'b0;
    w_nbr   = r_empty;
    case (r_cmd)
      3'b001:  begin w_legal = (w_row < LAST);   w_nbr = r_empty + DIM_I; end
      3'b010:  begin w_legal = (w_row != '0);    w_nbr = r_empty - DIM_I; end
      3'b011:  begin w_legal = (w_col < LAST);   w_nbr = r_empty + ONE;   end
      3'b100:  begin w_legal = (w_col != '0);    w_nbr = r_empty - ONE;   end
      default: begin w_legal = 1'b0;             w_nbr = r_empty;         end
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_code_ok) w_next = EXEC;
      EXEC:    w_next = w_legal ? WCHK : IDLE;
      WCHK:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (load) w_next = WCHK;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_cmd       <= '0;
      r_board     <= '0;
      r_empty     <= '0;
      r_cnt       <= '0;
      r_move_done <= 1'b0;
      r_illegal   <= 1'b0;
      r_win       <= 1'b0;
      r_from_load <= 1'b0;
    end else begin
      r_move_done <= 1'b0;
      r_illegal   <= 1'b0;
      if (load) begin
        r_board     <= init_board;
        r_empty     <= init_empty;
        r_cnt       <= '0;
        r_win       <= 1'b0;
        r_from_load <= 1'b1;
      end else begin
        case (r_state)
          IDLE: if (w_accept && w_code_ok) r_cmd <= cmd;
          EXEC: begin
            if (w_legal) begin
              r_board[r_empty*TILE_W +: TILE_W] <= w_tile;
              r_board[w_nbr*TILE_W +: TILE_W]   <= '0;
              r_empty     <= w_nbr;
              r_from_load <= 1'b0;
              if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            end else begin
              r_illegal <= 1'b1;
            end
          end
          WCHK: begin
            r_win       <= (r_board == SOLVED);
            r_move_done <= !r_from_load;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_ready  = (r_state == IDLE) && !load;
  assign board      = r_board;
  assign empty_idx  = r_empty;
  assign move_count = r_cnt;
  assign move_done  = r_move_done;
  assign illegal    = r_illegal;
  assign win        = r_win;

endmodule
